// File: rtl/pi_linebuffer.sv
// pi_linebuffer: captures active Pi DPI lines into four tagged line slots held
// in block RAM, and serves random-access (frame line, dot) reads for the VP415
// output-side compositor. Up to three completed lines of slack decouple the
// Pi timing from the VP415 timing.
module pi_linebuffer #(
   parameter int DATA_WIDTH = 18,
   parameter int LINE_DOTS  = 720,
   parameter int NUM_SLOTS  = 4
) (
   input  logic                  pixelClockX6,
   input  logic                  nReset,
   input  logic [2:0]            pixelClockPhase,
   input  logic                  displayEnabled_pi,
   input  logic [9:0]            fieldLineDot_pi,
   input  logic [9:0]            frameLine_pi,
   input  logic [DATA_WIDTH-1:0] pixelData_pi,
   input  logic                  rdEnable,
   input  logic [9:0]            rdLine,
   input  logic [9:0]            rdDot,
   output logic [DATA_WIDTH-1:0] rdData,
   output logic                  rdHit,
   output logic                  rdValid,
   output logic                  lineError,
   output logic                  overrun,
   output logic [15:0]           lineCount
);

   localparam int              SLOT_W    = $clog2(NUM_SLOTS);
   localparam int              ADDR_W    = 12;
   localparam int              MEM_DEPTH = NUM_SLOTS * LINE_DOTS;
   localparam logic [9:0]      LAST_DOT  = 10'(LINE_DOTS - 1);
   localparam logic [ADDR_W-1:0] DOTS_A  = ADDR_W'(LINE_DOTS);

   // Line storage: slot-major, slot*LINE_DOTS + dot
   logic [DATA_WIDTH-1:0] lineMem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] ramQ_reg;

   logic [9:0]            tag_reg [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  valid_reg;
   logic [SLOT_W-1:0]     writeSlot_reg;
   logic [9:0]            expectedDot_reg;
   logic                  writing_reg;
   logic                  lineError_reg;
   logic                  overrun_reg;
   logic [15:0]           lineCount_reg;
   logic [SLOT_W-1:0]     lastHitSlot_reg;
   logic                  lastHitValid_reg;
   logic                  rdValid_reg;
   logic                  rdHit_reg;

   // Write-side decode; only the phase-0 clock carries a fresh Pi pixel
   logic              pixelStrobe;
   logic              lineStart;
   logic              dotMatch;
   logic              lineEnd;
   logic              dotJump;
   logic              memWe;
   logic [ADDR_W-1:0] wrAddr;

   assign pixelStrobe = (pixelClockPhase == 3'd0) && displayEnabled_pi;
   assign lineStart   = pixelStrobe && (fieldLineDot_pi == 10'd0);
   assign dotMatch    = pixelStrobe && writing_reg && !lineStart &&
                        (fieldLineDot_pi == expectedDot_reg);
   assign lineEnd     = dotMatch && (fieldLineDot_pi == LAST_DOT);
   assign dotJump     = pixelStrobe && writing_reg && !lineStart &&
                        (fieldLineDot_pi != expectedDot_reg);
   assign memWe       = lineStart || dotMatch;
   assign wrAddr      = ADDR_W'(writeSlot_reg) * DOTS_A + ADDR_W'(fieldLineDot_pi);

   // Read-side tag lookup against the slot state as it stands before this edge
   logic [NUM_SLOTS-1:0] slotMatch;
   logic [SLOT_W-1:0]    hitSlot;
   logic                 lookupHit;
   logic [ADDR_W-1:0]    rdAddr;

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gTagCmp
         assign slotMatch[gi] = valid_reg[gi] && (tag_reg[gi] == rdLine);
      end
   endgenerate

   // Lowest matching slot index wins when tags are duplicated
   always_comb begin
      hitSlot = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (slotMatch[s]) hitSlot = SLOT_W'(s);
      end
   end

   assign lookupHit = (|slotMatch) && (rdDot <= LAST_DOT);
   assign rdAddr    = lookupHit ? (ADDR_W'(hitSlot) * DOTS_A + ADDR_W'(rdDot)) : '0;

   // Block RAM: one write port, one registered read port (read-before-write)
   always_ff @(posedge pixelClockX6) begin
      if (memWe) lineMem[wrAddr] <= pixelData_pi;
      if (rdEnable) ramQ_reg <= lineMem[rdAddr];
   end

   // Slot bookkeeping, sticky flags and read qualifiers
   always_ff @(posedge pixelClockX6 or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NUM_SLOTS; i++) tag_reg[i] <= '0;
         valid_reg        <= '0;
         writeSlot_reg    <= '0;
         expectedDot_reg  <= '0;
         writing_reg      <= 1'b0;
         lineError_reg    <= 1'b0;
         overrun_reg      <= 1'b0;
         lineCount_reg    <= '0;
         lastHitSlot_reg  <= '0;
         lastHitValid_reg <= 1'b0;
         rdValid_reg      <= 1'b0;
         rdHit_reg        <= 1'b0;
      end else begin
         if (lineStart) begin
            // Evicting the slot the compositor last hit means it lost its line
            if (valid_reg[writeSlot_reg] && lastHitValid_reg &&
                (lastHitSlot_reg == writeSlot_reg))
               overrun_reg <= 1'b1;
            valid_reg[writeSlot_reg] <= 1'b0;
            tag_reg[writeSlot_reg]   <= frameLine_pi;
            writing_reg              <= 1'b1;
            expectedDot_reg          <= 10'd1;
         end else if (dotMatch) begin
            if (lineEnd) begin
               valid_reg[writeSlot_reg] <= 1'b1;
               writeSlot_reg            <= writeSlot_reg + 1'b1;
               writing_reg              <= 1'b0;
               lineCount_reg            <= lineCount_reg + 16'd1;
            end else begin
               expectedDot_reg <= expectedDot_reg + 10'd1;
            end
         end else if (dotJump) begin
            lineError_reg <= 1'b1;
            writing_reg   <= 1'b0;
         end

         rdValid_reg <= rdEnable;
         if (rdEnable) begin
            rdHit_reg        <= lookupHit;
            lastHitValid_reg <= lookupHit;
            if (lookupHit) lastHitSlot_reg <= hitSlot;
         end
      end
   end

   // RAM output is only meaningful on a hit; a miss presents zero
   assign rdData    = rdHit_reg ? ramQ_reg : '0;
   assign rdHit     = rdHit_reg;
   assign rdValid   = rdValid_reg;
   assign lineError = lineError_reg;
   assign overrun   = overrun_reg;
   assign lineCount = lineCount_reg;

endmodule

// File: tb/tb_pi_linebuffer.sv
// Bench for pi_linebuffer: drives Pi lines and compositor reads, checking
// against a line-level model (current line as a queue, committed on the last dot).
module tb_pi_linebuffer;

   logic        clk = 1'b0;
   logic        nReset = 1'b1;
   logic [2:0]  phase = '0;
   logic        de = 1'b0;
   logic [9:0]  dot = '0;
   logic [9:0]  fline = '0;
   logic [17:0] pix = '0;
   logic        ren = 1'b0;
   logic [9:0]  rline = '0;
   logic [9:0]  rdot = '0;
   logic [17:0] rdData;
   logic        rdHit, rdValid, lineError, overrun;
   logic [15:0] lineCount;

   int checks = 0;
   int errors = 0;

   pi_linebuffer dut (
      .pixelClockX6(clk), .nReset(nReset), .pixelClockPhase(phase),
      .displayEnabled_pi(de), .fieldLineDot_pi(dot), .frameLine_pi(fline),
      .pixelData_pi(pix), .rdEnable(ren), .rdLine(rline), .rdDot(rdot),
      .rdData(rdData), .rdHit(rdHit), .rdValid(rdValid),
      .lineError(lineError), .overrun(overrun), .lineCount(lineCount)
   );

   always #5 clk = ~clk;

   // Line-level model
   logic [17:0] mMem [4][720];
   logic [9:0]  mTag [4];
   bit          mValid [4];
   int          mWs;
   bit          mWriting;
   logic [17:0] curPix [$];
   bit          mLineError, mOverrun;
   logic [15:0] mLineCount;
   int          mLastHitSlot;
   bit          mLastHitValid;
   bit          expHit;
   logic [17:0] expData;

   task automatic modelReset();
      for (int s = 0; s < 4; s++) begin mValid[s] = 0; mTag[s] = '0; end
      mWs = 0; mWriting = 0; curPix.delete();
      mLineError = 0; mOverrun = 0; mLineCount = '0;
      mLastHitSlot = 0; mLastHitValid = 0; expHit = 0; expData = '0;
   endtask

   task automatic modelPixel(input logic [9:0] d, input logic [9:0] ln, input logic [17:0] v);
      if (d == 10'd0) begin
         if (mValid[mWs] && mLastHitValid && mLastHitSlot == mWs) mOverrun = 1;
         mValid[mWs] = 0;
         mTag[mWs] = ln;
         curPix.delete();
         curPix.push_back(v);
         mWriting = 1;
      end else if (mWriting && int'(d) == curPix.size()) begin
         curPix.push_back(v);
         if (curPix.size() == 720) begin
            for (int i = 0; i < 720; i++) mMem[mWs][i] = curPix[i];
            mValid[mWs] = 1;
            mWs = (mWs + 1) % 4;
            mWriting = 0;
            mLineCount = mLineCount + 16'd1;
         end
      end else if (mWriting) begin
         mLineError = 1;
         mWriting = 0;
      end
   endtask

   // One clock: drive at negedge, update model, return #1 after posedge
   task automatic cycle(input logic [2:0] ph, input logic deIn, input logic [9:0] dotIn,
                        input logic [9:0] lineIn, input logic [17:0] dataIn,
                        input logic renIn, input logic [9:0] rlIn, input logic [9:0] rdIn);
      int hs;
      @(negedge clk);
      phase = ph; de = deIn; dot = dotIn; fline = lineIn; pix = dataIn;
      ren = renIn; rline = rlIn; rdot = rdIn;
      hs = -1;
      if (renIn) begin
         for (int s = 3; s >= 0; s--) if (mValid[s] && mTag[s] == rlIn) hs = s;
         if (rdIn >= 10'd720) hs = -1;
         expHit = (hs >= 0);
         expData = expHit ? mMem[hs][rdIn] : '0;
      end
      if (ph == 3'd0 && deIn) modelPixel(dotIn, lineIn, dataIn);
      if (renIn) begin
         mLastHitValid = (hs >= 0);
         if (hs >= 0) mLastHitSlot = hs;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doRead(input logic [9:0] ln, input logic [9:0] d);
      cycle(3'd3, 1'b0, 10'd0, 10'd0, 18'd0, 1'b1, ln, d);
   endtask

   task automatic idle();
      cycle(3'd2, 1'b0, 10'd0, 10'd0, 18'd0, 1'b0, 10'd0, 10'd0);
   endtask

   // Write dots first..last of a line, with occasional non-phase-0 junk clocks
   task automatic writeDots(input logic [9:0] ln, input int first, input int last, input bit dotData);
      for (int d = first; d <= last; d++) begin
         if ($urandom_range(0, 3) == 0)
            cycle(3'($urandom_range(1, 5)), 1'b1, 10'($urandom_range(0, 719)),
                  10'($urandom), 18'($urandom), 1'b0, 10'd0, 10'd0);
         cycle(3'd0, 1'b1, 10'(d), ln, dotData ? 18'(d) : 18'($urandom), 1'b0, 10'd0, 10'd0);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      ren = 0; de = 0;
      nReset = 0;
      #2;
      @(negedge clk);
      nReset = 1;
      modelReset();
   endtask

   task automatic test_reset();
      #12 nReset = 0;
      #1;
      checks++;
      if ({rdValid, rdHit, rdData, lineError, overrun, lineCount} !== 38'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b h=%b d=%h e=%b o=%b c=%0d, want all 0",
                  rdValid, rdHit, rdData, lineError, overrun, lineCount);
      end
      @(negedge clk) nReset = 1;
      modelReset();
      doRead(10'd0, 10'd0);
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL reset_read_miss: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
   endtask

   task automatic test_single_line();
      int dots [3] = '{0, 359, 719};
      doReset();
      writeDots(10'd10, 0, 719, 1'b1);
      foreach (dots[i]) begin
         doRead(10'd10, 10'(dots[i]));
         checks++;
         if ({rdValid, rdHit, rdData} !== {1'b1, 1'b1, 18'(dots[i])}) begin
            errors++;
            $display("FAIL single_read_%0d: got v=%b h=%b d=%0d, want v=1 h=1 d=%0d",
                     dots[i], rdValid, rdHit, rdData, dots[i]);
         end
      end
      idle();
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b0, 1'b1, 18'd719}) begin
         errors++;
         $display("FAIL single_hold: got v=%b h=%b d=%0d, want v=0 h=1 d=719", rdValid, rdHit, rdData);
      end
      checks++;
      if (lineCount !== 16'd1) begin
         errors++;
         $display("FAIL single_count: got %0d, want 1", lineCount);
      end
   endtask

   task automatic test_five_lines();
      int lines [4] = '{2, 4, 6, 8};
      doReset();
      for (int l = 0; l < 5; l++) writeDots(10'(2 * l), 0, 719, 1'b0);
      doRead(10'd0, 10'($urandom_range(0, 719)));
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL five_line0_miss: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
      foreach (lines[i]) begin
         doRead(10'(lines[i]), 10'($urandom_range(0, 719)));
         checks++;
         if ({rdValid, rdHit, rdData} !== {1'b1, 1'b1, expData}) begin
            errors++;
            $display("FAIL five_hit_%0d: got v=%b h=%b d=%h, want v=1 h=1 d=%h",
                     lines[i], rdValid, rdHit, rdData, expData);
         end
      end
      doRead(10'd8, 10'd720);
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL five_dot720: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
      checks++;
      if (dut.writeSlot_reg !== 2'd1) begin
         errors++;
         $display("FAIL five_writeslot: got %0d, want 1", dut.writeSlot_reg);
      end
      // Second copy of line 4 lands in slot 1; it must win over slot 2
      writeDots(10'd4, 0, 719, 1'b0);
      doRead(10'd4, 10'($urandom_range(0, 719)));
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b1, expData}) begin
         errors++;
         $display("FAIL dup_tag_lowest: got v=%b h=%b d=%h, want v=1 h=1 d=%h", rdValid, rdHit, rdData, expData);
      end
      checks++;
      if ({lineCount, overrun, lineError} !== {16'd6, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL five_status: got c=%0d o=%b e=%b, want c=6 o=0 e=0", lineCount, overrun, lineError);
      end
   endtask

   task automatic test_abort();
      doReset();
      writeDots(10'd15, 0, 399, 1'b0);
      for (int i = 0; i < 5; i++)
         cycle(3'd0, 1'b0, 10'(400 + i), 10'd15, 18'($urandom), 1'b0, 10'd0, 10'd0);
      writeDots(10'd20, 0, 719, 1'b0);
      for (int i = 0; i < 3; i++) begin
         doRead(10'd20, 10'($urandom_range(0, 719)));
         checks++;
         if ({rdValid, rdHit, rdData} !== {1'b1, 1'b1, expData}) begin
            errors++;
            $display("FAIL abort_hit: got v=%b h=%b d=%h, want v=1 h=1 d=%h", rdValid, rdHit, rdData, expData);
         end
      end
      doRead(10'd15, 10'd100);
      checks++;
      if ({rdHit, rdData} !== {1'b0, 18'd0}) begin
         errors++;
         $display("FAIL abort_old_miss: got h=%b d=%h, want h=0 d=0", rdHit, rdData);
      end
      checks++;
      if ({dut.writeSlot_reg, lineError, lineCount} !== {2'd1, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL abort_status: got slot=%0d e=%b c=%0d, want slot=1 e=0 c=1",
                  dut.writeSlot_reg, lineError, lineCount);
      end
   endtask

   task automatic test_discontinuity();
      doReset();
      writeDots(10'd25, 0, 100, 1'b0);
      cycle(3'd0, 1'b1, 10'd102, 10'd25, 18'($urandom), 1'b0, 10'd0, 10'd0);
      writeDots(10'd25, 103, 719, 1'b0);
      checks++;
      if ({lineError, lineCount} !== {1'b1, 16'd0}) begin
         errors++;
         $display("FAIL jump_error: got e=%b c=%0d, want e=1 c=0", lineError, lineCount);
      end
      doRead(10'd25, 10'd50);
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL jump_miss: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
      writeDots(10'd30, 0, 719, 1'b0);
      doRead(10'd30, 10'($urandom_range(0, 719)));
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b1, expData}) begin
         errors++;
         $display("FAIL jump_next_hit: got v=%b h=%b d=%h, want v=1 h=1 d=%h", rdValid, rdHit, rdData, expData);
      end
      checks++;
      if ({dut.writeSlot_reg, lineError, lineCount} !== {2'd1, 1'b1, 16'd1}) begin
         errors++;
         $display("FAIL jump_status: got slot=%0d e=%b c=%0d, want slot=1 e=1 c=1",
                  dut.writeSlot_reg, lineError, lineCount);
      end
   endtask

   task automatic test_overrun();
      logic [17:0] startPix;
      doReset();
      for (int l = 0; l < 5; l++) writeDots(10'(2 * l), 0, 719, 1'b0);
      doRead(10'd4, 10'($urandom_range(0, 719)));
      checks++;
      if ({rdHit, rdData} !== {1'b1, expData}) begin
         errors++;
         $display("FAIL ovr_first_hit: got h=%b d=%h, want h=1 d=%h", rdHit, rdData, expData);
      end
      writeDots(10'd12, 0, 719, 1'b0);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_early: got %b, want 0", overrun);
      end
      // Read of line 4 on the very edge that evicts slot 2: sees the old line
      startPix = 18'($urandom);
      cycle(3'd0, 1'b1, 10'd0, 10'd14, startPix, 1'b1, 10'd4, 10'd77);
      checks++;
      if ({rdValid, rdHit, rdData, overrun} !== {1'b1, 1'b1, expData, 1'b1}) begin
         errors++;
         $display("FAIL ovr_edge: got v=%b h=%b d=%h o=%b, want v=1 h=1 d=%h o=1",
                  rdValid, rdHit, rdData, overrun, expData);
      end
      cycle(3'd0, 1'b1, 10'd1, 10'd14, 18'($urandom), 1'b1, 10'd4, 10'd77);
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL ovr_after_miss: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
   endtask

   task automatic test_reset_midline();
      doReset();
      writeDots(10'd40, 0, 719, 1'b0);
      doRead(10'd40, 10'd5);
      writeDots(10'd41, 0, 500, 1'b0);
      #3 nReset = 0;
      #1;
      checks++;
      if ({rdValid, rdHit, rdData, lineError, overrun, lineCount} !== 38'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got v=%b h=%b d=%h e=%b o=%b c=%0d, want all 0",
                  rdValid, rdHit, rdData, lineError, overrun, lineCount);
      end
      @(negedge clk) nReset = 1;
      modelReset();
      doRead(10'd40, 10'd5);
      checks++;
      if ({rdValid, rdHit, rdData} !== {1'b1, 1'b0, 18'd0}) begin
         errors++;
         $display("FAIL midreset_miss: got v=%b h=%b d=%h, want v=1 h=0 d=0", rdValid, rdHit, rdData);
      end
      writeDots(10'd50, 0, 719, 1'b0);
      doRead(10'd50, 10'($urandom_range(0, 719)));
      checks++;
      if ({rdHit, rdData, dut.writeSlot_reg, lineCount} !== {1'b1, expData, 2'd1, 16'd1}) begin
         errors++;
         $display("FAIL midreset_slot0: got h=%b d=%h slot=%0d c=%0d, want h=1 d=%h slot=1 c=1",
                  rdHit, rdData, dut.writeSlot_reg, lineCount, expData);
      end
   endtask

   task automatic test_random();
      int d = 0;
      logic [9:0] ln;
      doReset();
      ln = 10'($urandom_range(0, 3));
      for (int c = 0; c < 6000; c++) begin
         logic [2:0] ph;
         logic dEn, rEn;
         int dd, r;
         ph  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
         dEn = 1'b1;
         dd  = d;
         r   = $urandom_range(0, 999);
         if (r < 2) dd = d + 2;
         else if (r < 5) dEn = 1'b0;
         rEn = 1'($urandom_range(0, 1));
         cycle(ph, dEn, 10'(dd), ln, 18'($urandom), rEn, 10'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 10'($urandom_range(720, 1023)) : 10'($urandom_range(0, 719)));
         checks++;
         if ({rdValid, rdHit, rdData} !== {rEn, expHit, expData}) begin
            errors++;
            $display("FAIL random_read c=%0d: got v=%b h=%b d=%h, want v=%b h=%b d=%h",
                     c, rdValid, rdHit, rdData, rEn, expHit, expData);
         end
         if (ph == 3'd0 && dEn) begin
            d = dd + 1;
            if (d >= 720) begin d = 0; ln = 10'($urandom_range(0, 3)); end
         end
      end
      checks++;
      if ({lineError, overrun, lineCount} !== {mLineError, mOverrun, mLineCount}) begin
         errors++;
         $display("FAIL random_status: got e=%b o=%b c=%0d, want e=%b o=%b c=%0d",
                  lineError, overrun, lineCount, mLineError, mOverrun, mLineCount);
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_single_line();
      test_five_lines();
      test_abort();
      test_discontinuity();
      test_overrun();
      test_reset_midline();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pi_linebuffer.md
Name: pi_linebuffer

Overview:
Downstream consumer of the Pi pixel tracker (fieldLineDot_pi, frameLine_pi, displayEnabled_pi) and the Pi DPI pixel bus. It captures each active Pi line into one of four line slots in internal block RAM, tagged with its frame line number. It gives the VP415 output-side compositor random-access reads by (frame line, dot). This decouples Pi timing from VP415 timing by up to three completed lines.

Parameters:
DATA_WIDTH, 18, Pi DPI pixel width (RGB666)
LINE_DOTS, 720, active dots per line
NUM_SLOTS, 4, line slots (power of two, fixed 4 in this revision)

Ports:
pixelClockX6  input  1  system clock (6x pixel clock)
nReset  input  1  asynchronous active-low reset
pixelClockPhase  input  3  pixel phase; write side acts only when 0
displayEnabled_pi  input  1  Pi active-video flag
fieldLineDot_pi  input  10  dot index of the current Pi pixel (0-719)
frameLine_pi  input  10  frame line of the current Pi line (0-575)
pixelData_pi  input  DATA_WIDTH  Pi pixel data
rdEnable  input  1  read strobe, any clock
rdLine  input  10  requested frame line
rdDot  input  10  requested dot
rdData  output  DATA_WIDTH  read data, 0 on miss
rdHit  output  1  requested line is resident and complete
rdValid  output  1  rdData/rdHit qualify this clock
lineError  output  1  sticky: dot discontinuity seen
overrun  output  1  sticky: slot evicted while last hit
lineCount  output  16  completed lines written, wraps

Behaviour:
- Reset is asynchronous and active-low. All slot tags are invalid, writeSlot=0, expectedDot=0, and writing=0. All outputs are 0.
- The write side samples only on the clock where pixelClockPhase==0. On that clock, fieldLineDot_pi is the index of the pixel currently on pixelData_pi.
- Line start: displayEnabled_pi=1 and dot==0.
  - Clear valid[writeSlot].
  - Latch tag[writeSlot]=frameLine_pi.
  - Write the pixel to mem[writeSlot][0].
  - Set writing=1 and expectedDot=1.
  - If valid[writeSlot] was set, writeSlot==lastHitSlot, and lastHitValid, set overrun.
- Mid-line: displayEnabled_pi=1, writing=1, and dot==expectedDot.
  - Write mem[writeSlot][dot] and increment expectedDot.
- Last pixel: dot==LINE_DOTS-1 is written.
  - On the same edge: valid[writeSlot]=1, writeSlot advances (mod 4), writing=0, and lineCount increments.
  - The new tag is visible to reads from the next clock onwards.
- Discontinuity: displayEnabled_pi=1, writing=1, and dot!=expectedDot with dot!=0.
  - Set lineError, set writing=0, and write nothing.
  - The slot stays invalid and writeSlot does not advance.
- A dot-0 start during writing=1 is a restart. It re-runs the line-start action in the same slot and does not set lineError.
- Aborted line: displayEnabled_pi drops with writing=1 before the last dot. writing stays 1, but no completion occurs. The next dot-0 start restarts the same slot. The slot never becomes valid.
- displayEnabled_pi=1 with writing=0 and dot!=0 is ignored (no error).
- Read side (every clock, phase independent):
  - When rdEnable=1, compare rdLine against all 4 tags, counting only valid slots.
  - On the next clock rdValid=1. On a hit, rdHit=1 and rdData=mem[hitSlot][rdDot]. On a miss, rdHit=0 and rdData=0.
  - rdDot>=LINE_DOTS gives rdHit=0, rdData=0.
  - On a hit, lastHitSlot=hitSlot and lastHitValid=1. On a miss, lastHitValid=0.
- Duplicate tags: if more than one valid slot matches rdLine, the lowest slot index wins.
- Read and write in the same clock: the read sees slot state before that edge's write or tag update. A read of a slot being cleared on that edge hits the old data.
- When rdEnable=0, rdValid=0 and rdData/rdHit hold their previous values.
- Width rules: memory depth is NUM_SLOTS*LINE_DOTS, addressed as slot*LINE_DOTS+dot (12-bit address). lineCount wraps 0xFFFF to 0.
- Reset mid-line discards all slots. The first line written after reset goes to slot 0.
- lineError and overrun clear only on reset.

Test Plan:
1. Reset, then one full line with frameLine=10 and data=dot. Read (10, 0), (10, 359), (10, 719) -> rdValid one clock later, rdHit=1, data 0/359/719, lineCount=1.
2. Write five complete lines, frameLine 0,2,4,6,8 -> line 0 misses (rdHit=0, rdData=0), lines 2-8 hit, writeSlot=1.
3. Write dots 0..399, drop displayEnabled, then write a full line with frameLine=20 -> read of 20 hits with the new data, writeSlot has advanced only once, lineError=0.
4. Jump dot 100 -> 102 mid-line -> lineError=1, the line reads as a miss, and the next complete line lands in the same slot.
5. Hit line 4 in slot 2, then start writing the line that reuses slot 2 -> overrun=1, and reads of line 4 miss from the dot-0 edge onwards.
6. Assert nReset at dot 500 of the second line -> all outputs 0, every read misses, and the next complete line is written to slot 0.
